// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and types for the register arbiter slice.
// Ports: none (package). Holds data/index/pending-count types and an x0 helper.
// Imported by register_arbiter_if, register_file and register_arbiter.
package cpu_pkg;

  localparam int DATA_WIDTH              = 32;
  localparam int NUM_REGISTERS           = 32;
  localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
  localparam int PENDING_WIDTH           = 2;

  typedef logic [DATA_WIDTH-1:0]              data_t;
  typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_idx_t;
  typedef logic [PENDING_WIDTH-1:0]           pending_t;

  // Largest number of in-flight writers a register can track.
  localparam pending_t PENDING_MAX = '1;

  // x0 is hardwired zero and never tracked.
  function automatic logic is_x0(reg_idx_t idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/register_arbiter_if.sv
// register_arbiter_if: bundle of issue, writeback and read-port signals.
// Ports: master = decode/retire side driving requests; slave = arbiter
// answering with issue_ready, read data, contention flags and underflow_error.
interface register_arbiter_if;
  import cpu_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_rd;
  logic     issue_ready;

  logic     writeback_valid;
  reg_idx_t writeback_rd;
  data_t    writeback_data;

  reg_idx_t read_1;
  reg_idx_t read_2;
  data_t    read_1_data;
  data_t    read_2_data;
  logic     read_1_contended;
  logic     read_2_contended;

  logic     underflow_error;

  modport master (
    output issue_valid, issue_rd, writeback_valid, writeback_rd, writeback_data,
           read_1, read_2,
    input  issue_ready, read_1_data, read_2_data, read_1_contended,
           read_2_contended, underflow_error
  );

  modport slave (
    input  issue_valid, issue_rd, writeback_valid, writeback_rd, writeback_data,
           read_1, read_2,
    output issue_ready, read_1_data, read_2_data, read_1_contended,
           read_2_contended, underflow_error
  );

endinterface

// File: rtl/register_file.sv
// register_file: 32 x 32-bit storage, two combinational reads, one write port.
// Ports: clk, rst (sync, active-high clear of all entries), write_en/addr/data,
// read_addr_1/2 -> read_data_1/2. Writes to x0 are dropped and x0 reads zero.
module register_file
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     write_en,
  input  reg_idx_t write_addr,
  input  data_t    write_data,
  input  reg_idx_t read_addr_1,
  input  reg_idx_t read_addr_2,
  output data_t    read_data_1,
  output data_t    read_data_2
);

  data_t mem [NUM_REGISTERS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en && !is_x0(write_addr)) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data_1 = is_x0(read_addr_1) ? '0 : mem[read_addr_1];
  assign read_data_2 = is_x0(read_addr_2) ? '0 : mem[read_addr_2];

endmodule

// File: rtl/register_arbiter.sv
// register_arbiter: scoreboard of pending writers per register plus storage.
// Ports: clk, rst (sync, active-high), bus (register_arbiter_if.slave).
// Optional macro REGISTER_ARBITER_BYPASS_EN forwards a retiring value to a
// reader in the same cycle when it clears the last pending writer.
module register_arbiter
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  register_arbiter_if.slave  bus
);

  pending_t pending      [NUM_REGISTERS];
  pending_t pending_next [NUM_REGISTERS];
  logic     underflow_q;

  logic     wb_live;
  logic     wb_same_issue;
  logic     issue_ready;
  logic     issue_accept;
  logic     underflow_hit;
  logic     bypass_1;
  logic     bypass_2;
  data_t    rf_data_1;
  data_t    rf_data_2;

  // Writebacks to x0 have no effect on anything, including the error flag.
  assign wb_live       = bus.writeback_valid && !is_x0(bus.writeback_rd);
  assign wb_same_issue = wb_live && (bus.writeback_rd == bus.issue_rd);

  // A full counter can still accept an issue when the same register retires
  // this cycle, since the net count does not move.
  assign issue_ready   = !rst && ((pending[bus.issue_rd] != PENDING_MAX) || wb_same_issue);
  assign issue_accept  = bus.issue_valid && issue_ready && !is_x0(bus.issue_rd);
  assign underflow_hit = wb_live && (pending[bus.writeback_rd] == '0);

  always_comb begin
    pending_next = pending;
    if (issue_accept && !wb_same_issue) begin
      pending_next[bus.issue_rd] = pending[bus.issue_rd] + 1'b1;
    end
    // Same-register issue+retire cancels; a retire at zero saturates at zero.
    if (wb_live && !(issue_accept && wb_same_issue) && !underflow_hit) begin
      pending_next[bus.writeback_rd] = pending[bus.writeback_rd] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        pending[i] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      pending     <= pending_next;
      underflow_q <= underflow_q || underflow_hit;
    end
  end

  register_file u_register_file (
    .clk         (clk),
    .rst         (rst),
    .write_en    (bus.writeback_valid && !rst),
    .write_addr  (bus.writeback_rd),
    .write_data  (bus.writeback_data),
    .read_addr_1 (bus.read_1),
    .read_addr_2 (bus.read_2),
    .read_data_1 (rf_data_1),
    .read_data_2 (rf_data_2)
  );

`ifdef REGISTER_ARBITER_BYPASS_EN
  // Only the last outstanding writer makes the value final; wb_live already
  // excludes x0 so the read index is non-zero whenever this fires.
  assign bypass_1 = wb_live && (bus.writeback_rd == bus.read_1) &&
                    (pending[bus.read_1] == pending_t'(1));
  assign bypass_2 = wb_live && (bus.writeback_rd == bus.read_2) &&
                    (pending[bus.read_2] == pending_t'(1));
`else
  assign bypass_1 = 1'b0;
  assign bypass_2 = 1'b0;
`endif

  assign bus.issue_ready      = issue_ready;
  assign bus.read_1_data      = bypass_1 ? bus.writeback_data : rf_data_1;
  assign bus.read_2_data      = bypass_2 ? bus.writeback_data : rf_data_2;
  assign bus.read_1_contended = rst || ((pending[bus.read_1] != '0) && !bypass_1);
  assign bus.read_2_contended = rst || ((pending[bus.read_2] != '0) && !bypass_2);
  assign bus.underflow_error  = underflow_q;

endmodule
